// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer slice.
//   seq_state_t   : sequencer FSM states (IDLE / RUN / DONE)
//   DIR_UP/DOWN   : direction encoding shared by cmd_dir and updown_core.dir
//   DEFAULT_WIDTH : default counter width in bits
package count_sequencer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/updown_core.sv
// WIDTH-bit synchronous up/down counter with parallel load.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, clears q
//   load     : load load_val into q (takes priority over en)
//   load_val : preload value
//   en       : step q by one in the direction given by dir
//   dir      : DIR_UP (+1) or DIR_DOWN (-1), wraps modulo 2^WIDTH
//   q        : counter value
module updown_core
   import count_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= (dir == DIR_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven count sequencer: preloads a counter with cmd_start and
// steps it up or down each un-held cycle until it reaches cmd_target,
// then emits a one-cycle done pulse.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   cmd_valid  : command request
//   cmd_ready  : command accept (high in IDLE)
//   cmd_dir    : 0 = up, 1 = down
//   cmd_start  : preload value
//   cmd_target : stop value
//   hold       : pause stepping while in RUN
//   abort      : cancel the running sequence (beats hold and completion)
//   cnt        : current count
//   busy       : high in RUN
//   done       : one-cycle completion pulse
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done
);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic             dir_q;
   logic [WIDTH-1:0] target_q;
   logic             load;
   logic             en;
   logic [WIDTH-1:0] step_val;

   updown_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (cmd_start),
      .en       (en),
      .dir      (dir_q),
      .q        (cnt)
   );

   // Value the counter will hold after this cycle's step, used to decide
   // completion on the same edge as the final step.
   assign step_val = (dir_q == DIR_DOWN) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         dir_q    <= DIR_UP;
         target_q <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            dir_q    <= cmd_dir;
            target_q <= cmd_target;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      en        = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               load      = 1'b1;
               state_nxt = (cmd_start == cmd_target) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (!hold) begin
               en = 1'b1;
               if (step_val == target_q) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are forced to their idle values while rst_n is low so that a
   // sequence interrupted by reset never shows busy or a done pulse.
   assign cmd_ready = (state == S_IDLE) || !rst_n;
   assign busy      = (state == S_RUN)  &&  rst_n;
   assign done      = (state == S_DONE) &&  rst_n;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept; a command transfers on an edge where cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_dir  in  1  direction: 0 = up, 1 = down (same sense as the team's mode input m).
REQ-007 cmd_start  in  WIDTH  preload value.
REQ-008 cmd_target  in  WIDTH  stop value.
REQ-009 hold  in  1  pause stepping while 1.
REQ-010 abort  in  1  cancel the running sequence.
REQ-011 cnt  out  WIDTH  current count.
REQ-012 busy  out  1  high in RUN.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding in shared package.
REQ-015 IDLE: cmd_ready=1, busy=0, done=0; cnt holds its value.
REQ-016 On a transfer in IDLE, at that edge: cnt<=cmd_start, latch cmd_dir and cmd_target; go to DONE if cmd_start==cmd_target, otherwise to RUN.
REQ-017 RUN: cmd_ready=0, busy=1; each edge with hold=0 and abort=0 steps cnt by +1 (dir=0) or -1 (dir=1), modulo 2^WIDTH.
REQ-018 Wrap-around is legal: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1; no error flag is raised.
REQ-019 When a step yields cnt==target, the FSM enters DONE on that same edge.
REQ-020 Step count from accept to DONE is (target-start) mod 2^WIDTH for up, or (start-target) mod 2^WIDTH for down, plus any held cycles.
REQ-021 hold=1 in RUN freezes cnt and state, with busy kept at 1.
REQ-022 abort=1 in RUN: go to IDLE next edge, cnt frozen at its current value, no done pulse.
REQ-023 abort has priority over hold and over a completing step.
REQ-024 abort and hold are ignored in IDLE and DONE.
REQ-025 DONE: done=1 for exactly one cycle, cmd_ready=0, busy=0; next edge returns unconditionally to IDLE.
REQ-026 cmd_valid outside IDLE is ignored; command inputs are sampled only on the transfer edge.
REQ-027 Back-to-back commands: minimum spacing is one IDLE cycle after DONE.

Reset
REQ-028 rst_n=0 at a rising edge forces: state=IDLE, cnt=0, latched dir=0, latched target=0.
REQ-029 Outputs during and after reset: cmd_ready=1, busy=0, done=0.
REQ-030 Reset mid-RUN or during DONE discards the sequence; no done pulse is emitted.
REQ-031 Reset overrides every other input in the same cycle.

Structure
REQ-032 Shared package holds: the state typedef (IDLE/RUN/DONE), the DIR_UP=0 / DIR_DOWN=1 constants, and the default WIDTH.
REQ-033 Sub-module updown_core holds the WIDTH-bit synchronous up/down counter.
REQ-034 updown_core ports: clk, rst_n, load, load_val, en, dir, q.
REQ-035 The count_sequencer FSM drives updown_core's load and en; no ripple or derived clocks are used.

Verification
REQ-036 Up run: start=3, target=7, dir=0, no hold -> cnt 3,4,5,6,7; done pulses the cycle after cnt becomes 7; busy high for 4 cycles.
REQ-037 Down wrap: start=1, target=14, dir=1 -> cnt 1,0,15,14; done once; busy high for 3 cycles.
REQ-038 Equal values: start=target=9 -> cnt=9, busy never high, done on the cycle after accept; then IDLE.
REQ-039 Hold/abort: start=0, target=15, up; hold=1 for 3 cycles at cnt=5 -> cnt stays 5 through the hold; abort at cnt=8 -> IDLE, cnt=8, done never asserted.
REQ-040 Priority: abort on the same edge as the final step (cnt=6, target=7) -> cnt stays 6, no done.
REQ-041 Reset mid-RUN: rst_n=0 at cnt=10 -> next cycle cnt=0, IDLE, cmd_ready=1.
REQ-042 Protocol: cmd_valid held during RUN -> not accepted until the IDLE cycle after DONE.
